wb_master_if: RTL
=================

WB_MASTER_IF -- requirements
Module: wb_master_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of cycles without ack before a bus cycle is aborted (used only when WB_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cpu_ce_i, input, 1 bit: the CPU requests an access.
REQ-005 SHALL have ports cpu_addr_i and cpu_data_i, input, 32 bits each: access address and write data.
REQ-006 SHALL have ports cpu_we_i (input, 1 bit) and cpu_sel_i (input, 4 bits): write enable and byte lane select.
REQ-007 SHALL have ports flush_i and stall_i, input, 1 bit each: pipeline flush, and stall requested by another pipeline source.
REQ-008 SHALL have port cpu_data_o, output, 32 bits: read data returned to the CPU.
REQ-009 SHALL have port stallreq_o, output, 1 bit: requests a pipeline stall while the access is pending.
REQ-010 SHALL have ports wb_data_i (input, 32 bits) and wb_ack_i (input, 1 bit): Wishbone read data and acknowledge.
REQ-011 SHALL have Wishbone outputs wb_addr_o (32), wb_data_o (32), wb_sel_o (4), wb_we_o (1), wb_stb_o (1) and wb_cyc_o (1).
REQ-012 SHALL have port bus_err_o, output, 1 bit: one-cycle pulse when a bus access is aborted by timeout.

Function
REQ-013 SHALL implement a 3-state FSM with states IDLE, BUSY and WAIT_STALL; the reset state is IDLE.
REQ-014 In IDLE with cpu_ce_i=1 and flush_i=0, SHALL on the next edge register addr/data/sel/we onto the Wishbone outputs, set cyc=stb=1 and enter BUSY.
REQ-015 In IDLE, stallreq_o SHALL equal cpu_ce_i AND NOT flush_i (combinational), and cpu_data_o SHALL be 0.
REQ-016 In BUSY with wb_ack_i=1, SHALL on the next edge clear cyc, stb, we, sel, addr and data to 0.
REQ-017 In BUSY with wb_ack_i=1, if it is a read, SHALL capture wb_data_i into rd_buf.
REQ-018 In BUSY with wb_ack_i=1, SHALL go to WAIT_STALL if stall_i=1, otherwise to IDLE.
REQ-019 In the BUSY ack cycle, stallreq_o SHALL be 0, and cpu_data_o SHALL be wb_data_i for a read or 0 for a write (zero-latency return).
REQ-020 In BUSY without ack, stallreq_o SHALL be 1.
REQ-021 In BUSY with flush_i=1 and no ack, SHALL on the next edge clear all Wishbone outputs, clear rd_buf and return to IDLE.
REQ-022 If ack and flush arrive in the same cycle, SHALL give ack priority.
REQ-023 In WAIT_STALL, stallreq_o SHALL be 0 and cpu_data_o SHALL be rd_buf; the FSM SHALL return to IDLE on the first cycle with stall_i=0.
REQ-024 If flush_i=1 in WAIT_STALL, SHALL go to IDLE and clear rd_buf.
REQ-025 While wb_cyc_o=1, wb_addr_o, wb_data_o, wb_sel_o and wb_we_o SHALL remain stable until ack, flush or timeout.
REQ-026 SHALL ignore wb_ack_i outside BUSY.

Reset
REQ-027 On rst=0, SHALL asynchronously set the state to IDLE, clear every Wishbone output, rd_buf and the timeout counter to 0, and drive bus_err_o to 0.
REQ-028 Reset asserted mid-cycle SHALL drop wb_cyc_o and wb_stb_o immediately, without waiting for a clock edge.
REQ-029 During reset, stallreq_o and cpu_data_o SHALL be 0.

Configuration
REQ-030 With macro WB_TIMEOUT_EN defined, SHALL count cycles spent in BUSY.
REQ-031 With WB_TIMEOUT_EN defined, SHALL reset the count on entry to BUSY.
REQ-032 With WB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without ack, SHALL clear the Wishbone outputs, pulse bus_err_o for one cycle, force cpu_data_o=0 and stallreq_o=0 in that cycle, and return to IDLE.
REQ-033 Without WB_TIMEOUT_EN, SHALL tie bus_err_o to 0, contain no counter, and wait in BUSY indefinitely.

Verification
REQ-034 Read 0x30000004, ack after 3 cycles with wb_data_i=0xDEADBEEF, stall_i=0 -> stallreq_o=1 for 3 cycles; cpu_data_o=0xDEADBEEF in the ack cycle; then IDLE with cyc=0.
REQ-035 Write 0x10000000 with data 0x55, sel=0001 -> wb_we_o=1 and wb_sel_o=0001 stable until ack; after ack all Wishbone outputs are 0.
REQ-036 Read with ack in the same cycle as stall_i=1 for 2 more cycles -> WAIT_STALL; cpu_data_o holds the captured value for 2 cycles; then IDLE.
REQ-037 flush_i=1 in the second BUSY cycle -> cyc=stb=0 on the next edge and IDLE; a late ack is ignored.
REQ-038 WB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack -> bus_err_o pulses once after 8 BUSY cycles; stallreq_o falls; cyc=0.
REQ-039 rst=0 asserted while in BUSY -> wb_cyc_o=0 asynchronously; after release the FSM is in IDLE and all outputs are 0.

Source files
------------

// File: rtl/wb_master_if.sv
// -----------------------------------------------------------------------------
// wb_master_if : CPU-side single-access Wishbone classic master.
//
// A CPU access request is latched onto the Wishbone outputs. The pipeline is
// stalled until the slave acknowledges. Read data is returned combinationally
// in the ack cycle. If the pipeline is stalled by another source in the ack
// cycle, the data is held in rd_buf until the stall clears.
//
// Optional feature: define WB_TIMEOUT_EN to abort a bus cycle that has waited
// TIMEOUT_CYCLES cycles without ack. An abort pulses bus_err_o. Without the
// macro, the counter is not built, bus_err_o is tied low, and BUSY waits
// indefinitely.
// -----------------------------------------------------------------------------
module wb_master_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // CPU side
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    // Wishbone side
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        bus_err_o
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_BUSY       = 2'd1;
    localparam logic [1:0] S_WAIT_STALL = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic [3:0]  r_wb_sel;
    logic        r_wb_we;
    logic        r_wb_stb;
    logic        r_wb_cyc;
    logic [31:0] r_rd_buf;

    logic        w_start;
    logic        w_ack_busy;
    logic        w_flush_busy;
    logic        w_flush_wait;
    logic        w_timeout;
    logic        w_busy_end;

    // An ack is only meaningful while a cycle is outstanding. Ack wins over a
    // simultaneous flush.
    assign w_start      = (r_state == S_IDLE) && cpu_ce_i && !flush_i;
    assign w_ack_busy   = (r_state == S_BUSY) && wb_ack_i;
    assign w_flush_busy = (r_state == S_BUSY) && !wb_ack_i && flush_i;
    assign w_flush_wait = (r_state == S_WAIT_STALL) && flush_i;
    assign w_busy_end   = w_ack_busy || w_flush_busy || w_timeout;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_tmo_cnt;

    // A timeout fires once TIMEOUT_CYCLES full BUSY cycles have passed
    // without an ack. The firing cycle is itself the error-pulse cycle.
    assign w_timeout = (r_state == S_BUSY) && !wb_ack_i &&
                       (r_tmo_cnt == CW'(TIMEOUT_CYCLES));

    // Count BUSY cycles, restarting from zero on every new bus cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (w_start) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_BUSY && !w_busy_end) begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
        end
    end

    assign bus_err_o = rst && w_timeout;
`else
    assign w_timeout = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    // Next-state selection for the IDLE / BUSY / WAIT_STALL controller.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (wb_ack_i) begin
                    w_state_next = stall_i ? S_WAIT_STALL : S_IDLE;
                end else if (flush_i || w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_STALL: begin
                if (flush_i || !stall_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wishbone request registers: loaded on start, held stable through BUSY,
    // cleared when the cycle ends by ack, flush or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_wb_cyc  <= 1'b0;
        end else if (w_start) begin
            r_wb_addr <= cpu_addr_i;
            r_wb_data <= cpu_data_i;
            r_wb_sel  <= cpu_sel_i;
            r_wb_we   <= cpu_we_i;
            r_wb_stb  <= 1'b1;
            r_wb_cyc  <= 1'b1;
        end else if (w_busy_end) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_stb  <= 1'b0;
            r_wb_cyc  <= 1'b0;
        end
    end

    // Read buffer: holds acked read data while the pipeline is stalled
    // elsewhere. A write ack clears it so stale read data is never returned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_buf <= '0;
        end else if (w_ack_busy) begin
            r_rd_buf <= r_wb_we ? 32'd0 : wb_data_i;
        end else if (w_flush_busy || w_flush_wait) begin
            r_rd_buf <= '0;
        end
    end

    // CPU-side responses: the stall request and the returned data. Both are
    // held low while reset is asserted.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    stallreq_o = cpu_ce_i && !flush_i;
                end
                S_BUSY: begin
                    stallreq_o = !wb_ack_i && !w_timeout;
                    if (wb_ack_i && !r_wb_we) begin
                        cpu_data_o = wb_data_i;
                    end
                end
                S_WAIT_STALL: begin
                    cpu_data_o = r_rd_buf;
                end
                default: begin
                    stallreq_o = 1'b0;
                    cpu_data_o = 32'd0;
                end
            endcase
        end
    end

    assign wb_addr_o = r_wb_addr;
    assign wb_data_o = r_wb_data;
    assign wb_sel_o  = r_wb_sel;
    assign wb_we_o   = r_wb_we;
    assign wb_stb_o  = r_wb_stb;
    assign wb_cyc_o  = r_wb_cyc;

endmodule
